// File: rtl/fetch_queue.sv
// Instruction fetch: PC generation, in-order imem requests and a small FIFO feeding decode.
// Define FETCH_QUEUE_PERF_EN to build the fetch/flush performance counters.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_flush_cnt
);

  localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          CW        = AW + 1;
  localparam logic [CW:0] DEPTH_SUM = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  logic [31:0]   pc;
  logic [31:0]   resp_pc;
  logic [CW-1:0] inflight;
  logic [CW-1:0] drop;
  logic [CW-1:0] count;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];

  logic          has_credit;
  logic          accept;
  logic          push;
  logic          pop;
  logic [CW-1:0] inflight_next;
  logic [31:0]   redirect_base;

  // A request may only go out if its word is guaranteed a FIFO slot on return.
  assign has_credit     = ({1'b0, count} + {1'b0, inflight}) < DEPTH_SUM;
  assign imem_req_valid = rstn && has_credit && !redirect_valid;
  assign imem_req_addr  = pc;
  assign accept         = imem_req_valid && imem_req_ready;

  assign redirect_base  = {redirect_pc[31:2], 2'b00};
  assign inflight_next  = inflight + CW'(accept) - CW'(imem_resp_valid);

  assign if_valid = (count != '0);
  assign if_pc    = if_valid ? pc_mem[rd_ptr]    : 32'h0;
  assign if_instr = if_valid ? instr_mem[rd_ptr] : 32'h0;

  assign pop  = if_valid && if_ready && !redirect_valid;
  assign push = imem_resp_valid && (drop == '0) && !redirect_valid;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc       <= RESET_PC;
      resp_pc  <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      inflight <= inflight_next;
      // Everything still outstanding after this cycle belongs to the old path.
      if (redirect_valid) begin
        pc      <= redirect_base;
        resp_pc <= redirect_base;
        drop    <= inflight_next;
        count   <= '0;
        rd_ptr  <= '0;
        wr_ptr  <= '0;
      end else begin
        if (accept) begin
          pc <= pc + 32'd4;
        end
        if (push) begin
          resp_pc <= resp_pc + 32'd4;
          wr_ptr  <= wr_ptr + AW'(1);
        end
        if (imem_resp_valid && (drop != '0)) begin
          drop <= drop - CW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= resp_pc;
      instr_mem[wr_ptr] <= imem_resp_data;
    end
  end

  // Credit accounting should make a write into a full FIFO impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
    !(push && !pop && (count == DEPTH_CNT)));

  a_inflight_bound: assert property (@(posedge clk) disable iff (!rstn)
    (inflight <= DEPTH_CNT) && (drop <= DEPTH_CNT));

`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] fetch_cnt;
  logic [31:0] flush_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fetch_cnt <= 32'h0;
      flush_cnt <= 32'h0;
    end else begin
      if (pop) begin
        fetch_cnt <= fetch_cnt + 32'd1;
      end
      if (redirect_valid) begin
        flush_cnt <= flush_cnt + 32'd1;
      end
    end
  end

  assign perf_fetch_cnt = fetch_cnt;
  assign perf_flush_cnt = flush_cnt;
`else
  assign perf_fetch_cnt = 32'h0;
  assign perf_flush_cnt = 32'h0;
`endif

endmodule
